// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one byte-serial memory controller between
// instruction fetch (IF) and load/store (LSB). Grants are LSB-first with a
// bounded number of consecutive LSB wins while IF waits. The granted payload
// is latched and held until the controller completes. Every transaction is
// followed by one idle GAP cycle so the controller's byte counter rewinds.
// A flush during an IF fetch lets the fetch finish (DRAIN) and drops its data.
module mem_req_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int STARVE_W     = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_in,
   input  logic        if_req_in,
   input  logic [31:0] if_addr_in,
   output logic        if_done_out,
   output logic [31:0] if_data_out,
   input  logic        lsb_req_in,
   input  logic        lsb_rw_in,
   input  logic [31:0] lsb_addr_in,
   input  logic [31:0] lsb_data_in,
   input  logic [2:0]  lsb_len_in,
   output logic        lsb_done_out,
   output logic [31:0] lsb_data_out,
   output logic        mc_enable_out,
   output logic        mc_rw_out,
   output logic [31:0] mc_addr_out,
   output logic [31:0] mc_data_out,
   output logic [2:0]  mc_len_out,
   input  logic        mc_done_in,
   input  logic [31:0] mc_data_in
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_BUSY_IF  = 3'd1,
      S_BUSY_LSB = 3'd2,
      S_DRAIN    = 3'd3,
      S_GAP      = 3'd4
   } state_t;

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
   localparam logic [2:0]          IF_LEN     = 3'd4;

   state_t              state_q, state_d;
   logic [STARVE_W-1:0] starve_q, starve_d;

   logic        if_eff;
   logic        if_forced;
   logic        grant_if;
   logic        grant_lsb;

   logic        mc_enable_q, mc_enable_d;
   logic        mc_rw_q, mc_rw_d;
   logic [31:0] mc_addr_q, mc_addr_d;
   logic [31:0] mc_data_q, mc_data_d;
   logic [2:0]  mc_len_q, mc_len_d;
   logic        if_done_q, if_done_d;
   logic [31:0] if_data_q, if_data_d;
   logic        lsb_done_q, lsb_done_d;
   logic [31:0] lsb_data_q, lsb_data_d;

   // Arbitration decision: only meaningful in IDLE; a flushed IF request is invisible.
   always_comb begin
      if_eff    = if_req_in & ~flush_in;
      if_forced = if_eff & (starve_q == STARVE_MAX);
      grant_if  = 1'b0;
      grant_lsb = 1'b0;
      if (state_q == S_IDLE) begin
         if (if_forced) begin
            grant_if = 1'b1;
         end else if (lsb_req_in) begin
            grant_lsb = 1'b1;
         end else if (if_eff) begin
            grant_if = 1'b1;
         end
      end
   end

   // Starvation counter: counts LSB wins over a waiting IF, reset when IF wins or stops asking.
   always_comb begin
      starve_d = starve_q;
      if (state_q == S_IDLE) begin
         if (grant_if || !if_req_in) begin
            starve_d = '0;
         end else if (grant_lsb && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

   // State and starvation counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Next-state logic: controller cannot abort, so a flushed fetch drains to completion.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_if) begin
               state_d = S_BUSY_IF;
            end else if (grant_lsb) begin
               state_d = S_BUSY_LSB;
            end
         end
         S_BUSY_IF: begin
            if (mc_done_in) begin
               state_d = S_GAP;
            end else if (flush_in) begin
               state_d = S_DRAIN;
            end
         end
         S_BUSY_LSB: begin
            if (mc_done_in) begin
               state_d = S_GAP;
            end
         end
         S_DRAIN: begin
            if (mc_done_in) begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output next-values: latch payload at grant, release enable and post results on completion.
   always_comb begin
      mc_enable_d = mc_enable_q;
      mc_rw_d     = mc_rw_q;
      mc_addr_d   = mc_addr_q;
      mc_data_d   = mc_data_q;
      mc_len_d    = mc_len_q;
      if_done_d   = 1'b0;
      if_data_d   = if_data_q;
      lsb_done_d  = 1'b0;
      lsb_data_d  = lsb_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_if) begin
               mc_enable_d = 1'b1;
               mc_rw_d     = 1'b0;
               mc_addr_d   = if_addr_in;
               mc_data_d   = '0;
               mc_len_d    = IF_LEN;
            end else if (grant_lsb) begin
               mc_enable_d = 1'b1;
               mc_rw_d     = lsb_rw_in;
               mc_addr_d   = lsb_addr_in;
               mc_data_d   = lsb_data_in;
               mc_len_d    = lsb_len_in;
            end
         end
         S_BUSY_IF: begin
            if (mc_done_in) begin
               mc_enable_d = 1'b0;
               // A flush arriving with completion still discards the fetch.
               if (!flush_in) begin
                  if_done_d = 1'b1;
                  if_data_d = mc_data_in;
               end
            end
         end
         S_BUSY_LSB: begin
            if (mc_done_in) begin
               mc_enable_d = 1'b0;
               lsb_done_d  = 1'b1;
               lsb_data_d  = mc_rw_q ? 32'h0 : mc_data_in;
            end
         end
         S_DRAIN: begin
            if (mc_done_in) begin
               mc_enable_d = 1'b0;
            end
         end
         S_GAP: begin
            mc_enable_d = 1'b0;
         end
         default: begin
            mc_enable_d = 1'b0;
         end
      endcase
   end

   // Output registers: every port is driven straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mc_enable_q <= 1'b0;
         mc_rw_q     <= 1'b0;
         mc_addr_q   <= '0;
         mc_data_q   <= '0;
         mc_len_q    <= '0;
         if_done_q   <= 1'b0;
         if_data_q   <= '0;
         lsb_done_q  <= 1'b0;
         lsb_data_q  <= '0;
      end else begin
         mc_enable_q <= mc_enable_d;
         mc_rw_q     <= mc_rw_d;
         mc_addr_q   <= mc_addr_d;
         mc_data_q   <= mc_data_d;
         mc_len_q    <= mc_len_d;
         if_done_q   <= if_done_d;
         if_data_q   <= if_data_d;
         lsb_done_q  <= lsb_done_d;
         lsb_data_q  <= lsb_data_d;
      end
   end

   assign mc_enable_out = mc_enable_q;
   assign mc_rw_out     = mc_rw_q;
   assign mc_addr_out   = mc_addr_q;
   assign mc_data_out   = mc_data_q;
   assign mc_len_out    = mc_len_q;
   assign if_done_out   = if_done_q;
   assign if_data_out   = if_data_q;
   assign lsb_done_out  = lsb_done_q;
   assign lsb_data_out  = lsb_data_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: requester and controller models with a
// scoreboard of expected controller transactions and expected done results.
module tb_mem_req_arbiter;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush_in = 1'b0;
   logic        if_req_in = 1'b0;
   logic [31:0] if_addr_in = '0;
   logic        if_done_out;
   logic [31:0] if_data_out;
   logic        lsb_req_in = 1'b0;
   logic        lsb_rw_in = 1'b0;
   logic [31:0] lsb_addr_in = '0;
   logic [31:0] lsb_data_in = '0;
   logic [2:0]  lsb_len_in = '0;
   logic        lsb_done_out;
   logic [31:0] lsb_data_out;
   logic        mc_enable_out;
   logic        mc_rw_out;
   logic [31:0] mc_addr_out;
   logic [31:0] mc_data_out;
   logic [2:0]  mc_len_out;
   logic        mc_done_in = 1'b0;
   logic [31:0] mc_data_in = '0;

   mem_req_arbiter #(.STARVE_LIMIT(4), .STARVE_W(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush_in     (flush_in),
      .if_req_in    (if_req_in),
      .if_addr_in   (if_addr_in),
      .if_done_out  (if_done_out),
      .if_data_out  (if_data_out),
      .lsb_req_in   (lsb_req_in),
      .lsb_rw_in    (lsb_rw_in),
      .lsb_addr_in  (lsb_addr_in),
      .lsb_data_in  (lsb_data_in),
      .lsb_len_in   (lsb_len_in),
      .lsb_done_out (lsb_done_out),
      .lsb_data_out (lsb_data_out),
      .mc_enable_out(mc_enable_out),
      .mc_rw_out    (mc_rw_out),
      .mc_addr_out  (mc_addr_out),
      .mc_data_out  (mc_data_out),
      .mc_len_out   (mc_len_out),
      .mc_done_in   (mc_done_in),
      .mc_data_in   (mc_data_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rw;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  len;
   } op_t;

   op_t         exp_mc[$];
   op_t         lsb_todo[$];
   logic [31:0] if_todo[$];
   logic [31:0] exp_if_done[$];
   logic [31:0] exp_lsb_done[$];

   int vectors = 0;
   int miscompares = 0;

   bit          if_active = 1'b0;
   bit          lsb_active = 1'b0;
   bit          busy = 1'b0;
   bit          seen_tx = 1'b0;
   bit          prev_if_done = 1'b0;
   bit          prev_lsb_done = 1'b0;
   int          cnt = 0;
   int          low_cnt = 0;
   int          flush_mode = 0;
   op_t         cur;
   op_t         op;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
   endfunction

   function automatic int pending();
      return lsb_todo.size() + if_todo.size() + exp_mc.size() + exp_if_done.size()
             + exp_lsb_done.size() + int'(if_active) + int'(lsb_active) + int'(busy);
   endfunction

   task automatic exp_tx(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] len);
      op_t e;
      e.rw = rw; e.addr = addr; e.data = data; e.len = len;
      exp_mc.push_back(e);
   endtask

   task automatic req_lsb(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] len);
      op_t e;
      e.rw = rw; e.addr = addr; e.data = data; e.len = len;
      lsb_todo.push_back(e);
   endtask

   task automatic wait_quiet(input string tag);
      int n;
      n = 0;
      while (n < 400 && pending() != 0) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq({tag, "_quiet"}, 64'(pending()), 64'(0));
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Requester, controller and done monitors, all acting on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         busy = 1'b0; seen_tx = 1'b0; low_cnt = 0; cnt = 0;
         mc_done_in = 1'b0; mc_data_in = '0; flush_in = 1'b0; flush_mode = 0;
         if_req_in = 1'b0; lsb_req_in = 1'b0; if_active = 1'b0; lsb_active = 1'b0;
         prev_if_done = 1'b0; prev_lsb_done = 1'b0;
         if_todo.delete(); lsb_todo.delete(); exp_if_done.delete(); exp_lsb_done.delete();
      end else begin
         if (if_done_out) begin
            check_eq("if_done_width", 64'(prev_if_done), 64'(0));
            check_eq("if_done_gap_en", 64'(mc_enable_out), 64'(0));
            if (exp_if_done.size() == 0) check_eq("if_done_unexpected", 64'(if_done_out), 64'(0));
            else check_eq("if_data", 64'(if_data_out), 64'(exp_if_done.pop_front()));
            if_req_in = 1'b0; if_active = 1'b0;
         end
         prev_if_done = if_done_out;
         if (lsb_done_out) begin
            check_eq("lsb_done_width", 64'(prev_lsb_done), 64'(0));
            check_eq("lsb_done_gap_en", 64'(mc_enable_out), 64'(0));
            if (exp_lsb_done.size() == 0) check_eq("lsb_done_unexpected", 64'(lsb_done_out), 64'(0));
            else check_eq("lsb_data", 64'(lsb_data_out), 64'(exp_lsb_done.pop_front()));
            lsb_req_in = 1'b0; lsb_active = 1'b0;
         end
         prev_lsb_done = lsb_done_out;

         mc_done_in = 1'b0;
         flush_in = 1'b0;
         if (!busy) begin
            if (mc_enable_out) begin
               if (seen_tx) check_eq("mc_idle_gap", 64'(low_cnt >= 2), 64'(1));
               seen_tx = 1'b1; low_cnt = 0; busy = 1'b1; cnt = LAT;
               cur.rw = mc_rw_out; cur.addr = mc_addr_out; cur.data = mc_data_out; cur.len = mc_len_out;
               check_eq("mc_tx_expected", 64'(exp_mc.size() != 0), 64'(1));
               if (exp_mc.size() != 0) begin
                  op = exp_mc.pop_front();
                  check_eq("mc_addr", 64'(mc_addr_out), 64'(op.addr));
                  check_eq("mc_rw_len", 64'({mc_rw_out, mc_len_out}), 64'({op.rw, op.len}));
                  if (op.rw) check_eq("mc_wdata", 64'(mc_data_out), 64'(op.data));
               end
               if (flush_mode == 1) begin flush_in = 1'b1; flush_mode = 0; end
            end else begin
               low_cnt++;
            end
         end else begin
            check_eq("mc_hold_ctl", 64'({mc_enable_out, mc_rw_out, mc_len_out}),
                     64'({1'b1, cur.rw, cur.len}));
            check_eq("mc_hold_addr", 64'(mc_addr_out), 64'(cur.addr));
            cnt--;
            if (cnt == 0) begin
               mc_done_in = 1'b1;
               mc_data_in = mem_rd(cur.addr);
               busy = 1'b0;
               if (flush_mode == 2) begin flush_in = 1'b1; flush_mode = 0; end
            end
         end

         if (flush_in && if_active) begin
            if_active = 1'b0; if_req_in = 1'b0;
            if (exp_if_done.size() != 0) exp_if_done.delete(exp_if_done.size() - 1);
         end
         if (!if_active && if_todo.size() != 0) begin
            if_addr_in = if_todo.pop_front();
            if_req_in = 1'b1; if_active = 1'b1;
            exp_if_done.push_back(mem_rd(if_addr_in));
         end
         if (!lsb_active && lsb_todo.size() != 0) begin
            op = lsb_todo.pop_front();
            lsb_rw_in = op.rw; lsb_addr_in = op.addr; lsb_data_in = op.data; lsb_len_in = op.len;
            lsb_req_in = 1'b1; lsb_active = 1'b1;
            exp_lsb_done.push_back(op.rw ? 32'h0 : mem_rd(op.addr));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // power-on reset
      #1 rst = 1'b1;
      #1;
      check_eq("rst_ctl", 64'({if_done_out, lsb_done_out, mc_enable_out, mc_rw_out, mc_len_out}), 64'(0));
      check_eq("rst_mc_bus", {mc_addr_out, mc_data_out}, 64'(0));
      @(posedge clk); #3 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // reset in the middle of an LSB transaction
      req_lsb(1'b0, 32'h4000, 32'h0, 3'd4);
      exp_tx(1'b0, 32'h4000, 32'h0, 3'd4);
      for (int i = 0; i < 20 && !mc_enable_out; i++) begin @(posedge clk); #1; end
      check_eq("t1_busy_before_rst", 64'(mc_enable_out), 64'(1));
      @(posedge clk); #3 rst = 1'b1;
      #1;
      check_eq("t1_rst_ctl", 64'({if_done_out, lsb_done_out, mc_enable_out, mc_rw_out, mc_len_out}), 64'(0));
      check_eq("t1_rst_mc_bus", {mc_addr_out, mc_data_out}, 64'(0));
      check_eq("t1_rst_data", {if_data_out, lsb_data_out}, 64'(0));
      @(posedge clk); #3 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("t1_idle_after_rst", 64'(mc_enable_out), 64'(0));

      // IF only
      if_todo.push_back(32'h100);
      exp_tx(1'b0, 32'h100, 32'h0, 3'd4);
      wait_quiet("t2");
      check_eq("t2_if_data_hold", 64'(if_data_out), 64'(32'h13));

      // simultaneous IF and LSB load: LSB first
      req_lsb(1'b0, 32'h2000, 32'h0, 3'd4);
      if_todo.push_back(32'h100);
      exp_tx(1'b0, 32'h2000, 32'h0, 3'd4);
      exp_tx(1'b0, 32'h100, 32'h0, 3'd4);
      wait_quiet("t3");

      // IF held while LSB re-requests: IF forced after four LSB wins, twice
      if_todo.push_back(32'h100);
      if_todo.push_back(32'h104);
      for (int i = 0; i < 8; i++) req_lsb(1'b0, 32'h3000 + 32'(4 * i), 32'h0, 3'd4);
      for (int i = 0; i < 4; i++) exp_tx(1'b0, 32'h3000 + 32'(4 * i), 32'h0, 3'd4);
      exp_tx(1'b0, 32'h100, 32'h0, 3'd4);
      for (int i = 4; i < 8; i++) exp_tx(1'b0, 32'h3000 + 32'(4 * i), 32'h0, 3'd4);
      exp_tx(1'b0, 32'h104, 32'h0, 3'd4);
      wait_quiet("t4");

      // flush during an IF fetch, then flush coinciding with completion
      flush_mode = 1;
      if_todo.push_back(32'h200);
      if_todo.push_back(32'h240);
      exp_tx(1'b0, 32'h200, 32'h0, 3'd4);
      exp_tx(1'b0, 32'h240, 32'h0, 3'd4);
      wait_quiet("t5a");
      check_eq("t5a_if_data", 64'(if_data_out), 64'(mem_rd(32'h240)));
      flush_mode = 2;
      if_todo.push_back(32'h280);
      if_todo.push_back(32'h2C0);
      exp_tx(1'b0, 32'h280, 32'h0, 3'd4);
      exp_tx(1'b0, 32'h2C0, 32'h0, 3'd4);
      wait_quiet("t5b");

      // store with flush mid-way: never dropped
      flush_mode = 1;
      req_lsb(1'b1, 32'h30000, 32'hAABBCCDD, 3'd2);
      exp_tx(1'b1, 32'h30000, 32'hAABBCCDD, 3'd2);
      wait_quiet("t6");
      check_eq("t6_lsb_data_zero", 64'(lsb_data_out), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
